// File: rtl/ddr_dly_pkg.sv
// Shared types for the DDR3 PHY IOD delay-line tap controller: command
// encodings, controller states and the lane-index width helper.
package ddr_dly_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOVE,
    ST_SETTLE,
    ST_DONE
  } state_e;

  // A single lane still needs a one-bit lane field.
  function automatic int lane_w(input int num_lanes);
    return (num_lanes <= 1) ? 1 : $clog2(num_lanes);
  endfunction

endpackage

// File: rtl/ddr_dly_tap_ctrl.sv
// Multi-lane IOD delay-line tap controller: turns LOAD/INC/DEC commands into
// spaced LOAD/MOVE/DIRECTION strobes, mirrors every lane's tap and enforces bounds.
module ddr_dly_tap_ctrl
  import ddr_dly_pkg::*;
#(
  parameter int NUM_LANES  = 2,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 255,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4,
  parameter int STEP_W     = 4,
  parameter int LANE_W     = lane_w(NUM_LANES)
) (
  input  logic                       fab_clk,
  input  logic                       arst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [LANE_W-1:0]          cmd_lane,
  input  logic [STEP_W-1:0]          cmd_steps,
  output logic                       done,
  output logic                       done_err,
  output logic [NUM_LANES-1:0]       delay_line_move,
  output logic [NUM_LANES-1:0]       delay_line_direction,
  output logic [NUM_LANES-1:0]       delay_line_load,
  input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
  output logic [NUM_LANES*TAP_W-1:0] tap_val
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  if (INIT_TAP > MAX_TAP) begin : g_chk_init
    $error("INIT_TAP must not exceed MAX_TAP");
  end
  if (MAX_TAP > (2 ** TAP_W) - 1) begin : g_chk_max
    $error("MAX_TAP does not fit in TAP_W bits");
  end
  if (SETTLE_CYC < 1) begin : g_chk_settle
    $error("SETTLE_CYC must be at least 1");
  end

  state_e                 state_q, state_d;
  cmd_op_e                op_q;
  cmd_op_e                op_in;
  logic [LANE_W-1:0]      lane_q;
  logic [STEP_W-1:0]      rem_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_q;
  logic [TAP_W-1:0]       tap_q [NUM_LANES];
  logic [TAP_W-1:0]       cur_tap;
  logic [NUM_LANES-1:0]   lane_mask;
  logic                   lane_bad;
  logic                   blocked;
  logic                   settle_last;
  logic                   move_go;
  logic [NUM_LANES-1:0]   move_d, load_d;
  logic                   done_d, done_err_d;

  assign op_in       = cmd_op_e'(cmd_op);
  assign lane_bad    = int'(cmd_lane) >= NUM_LANES;
  assign cur_tap     = tap_q[lane_q];
  assign lane_mask   = NUM_LANES'(1) << lane_q;
  assign settle_last = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  assign blocked     = ((op_q == OP_INC) && (cur_tap == TAP_W'(MAX_TAP))) ||
                       ((op_q == OP_DEC) && (cur_tap == '0)) ||
                       delay_line_out_of_range[lane_q];
  assign cmd_ready   = (state_q == ST_IDLE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    move_go    = 1'b0;
    move_d     = '0;
    load_d     = '0;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (lane_bad) begin
            state_d = ST_DONE;
          end else begin
            unique case (op_in)
              OP_LOAD:        state_d = ST_LOAD;
              OP_INC, OP_DEC: state_d = (cmd_steps == '0) ? ST_DONE : ST_MOVE;
              default:        state_d = ST_DONE;
            endcase
          end
        end
      end
      ST_LOAD: begin
        load_d  = lane_mask;
        state_d = ST_SETTLE;
      end
      ST_MOVE: begin
        if (blocked) begin
          state_d = ST_DONE;
        end else begin
          move_go = 1'b1;
          move_d  = lane_mask;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_last) state_d = (rem_q != '0) ? ST_MOVE : ST_DONE;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        done_err_d = err_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Strobes and completion are registered, so they trail the state by one cycle.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      delay_line_move      <= '0;
      delay_line_load      <= '0;
      delay_line_direction <= '0;
      done                 <= 1'b0;
      done_err             <= 1'b0;
      op_q                 <= OP_NOP;
      lane_q               <= '0;
      rem_q                <= '0;
      cnt_q                <= '0;
      err_q                <= 1'b0;
      // NOTE: the tap mirror is a small register array, not RAM; it must come
      // out of reset at INIT_TAP to match the IOD, so every entry is reset.
      for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= TAP_W'(INIT_TAP);
    end else begin
      delay_line_move <= move_d;
      delay_line_load <= load_d;
      done            <= done_d;
      done_err        <= done_err_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_in;
            lane_q <= cmd_lane;
            rem_q  <= cmd_steps;
            err_q  <= lane_bad;
            // Direction settles a full cycle ahead of the first MOVE pulse.
            if (!lane_bad && (op_in == OP_INC || op_in == OP_DEC) && cmd_steps != '0)
              delay_line_direction[cmd_lane] <= (op_in == OP_INC);
          end
        end
        ST_LOAD: begin
          tap_q[lane_q] <= TAP_W'(INIT_TAP);
          rem_q         <= '0;
          cnt_q         <= '0;
        end
        ST_MOVE: begin
          cnt_q <= '0;
          if (move_go) begin
            tap_q[lane_q] <= (op_q == OP_INC) ? cur_tap + 1'b1 : cur_tap - 1'b1;
            rem_q         <= rem_q - 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        ST_SETTLE: cnt_q <= cnt_q + 1'b1;
        ST_DONE:   err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_tap
    assign tap_val[g*TAP_W +: TAP_W] = tap_q[g];
  end

endmodule

// File: tb/tb_ddr_dly_tap_ctrl.sv
// Self-checking bench for ddr_dly_tap_ctrl: directed vector table, bound and
// reset sequences, and random commands against a timeline model of the rules.
module tb_ddr_dly_tap_ctrl;
  import ddr_dly_pkg::*;

  localparam int NL   = 2;
  localparam int TW   = 8;
  localparam int MAXT = 255;
  localparam int INIT = 1;
  localparam int S    = 4;
  localparam int SW   = 4;
  localparam int LW   = lane_w(NL);
  localparam int LW3  = lane_w(3);

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  logic             cmd_valid, cmd_ready, done, done_err;
  logic [1:0]       cmd_op;
  logic [LW-1:0]    cmd_lane;
  logic [SW-1:0]    cmd_steps;
  logic [NL-1:0]    mv, dir, ld, oor;
  logic [NL*TW-1:0] tap_val;

  logic             c3_valid, c3_ready, c3_done, c3_err;
  logic [1:0]       c3_op;
  logic [LW3-1:0]   c3_lane;
  logic [SW-1:0]    c3_steps;
  logic [2:0]       c3_mv, c3_dir, c3_ld, c3_oor;
  logic [3*TW-1:0]  c3_tap;

  ddr_dly_tap_ctrl #(.NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAXT), .INIT_TAP(INIT),
                     .SETTLE_CYC(S), .STEP_W(SW)) dut (
    .fab_clk(clk), .arst_n(arst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_steps(cmd_steps), .done(done),
    .done_err(done_err), .delay_line_move(mv), .delay_line_direction(dir),
    .delay_line_load(ld), .delay_line_out_of_range(oor), .tap_val(tap_val)
  );

  ddr_dly_tap_ctrl #(.NUM_LANES(3), .TAP_W(TW), .MAX_TAP(MAXT), .INIT_TAP(INIT),
                     .SETTLE_CYC(S), .STEP_W(SW)) dut3 (
    .fab_clk(clk), .arst_n(arst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_op(c3_op), .cmd_lane(c3_lane), .cmd_steps(c3_steps), .done(c3_done),
    .done_err(c3_err), .delay_line_move(c3_mv), .delay_line_direction(c3_dir),
    .delay_line_load(c3_ld), .delay_line_out_of_range(c3_oor), .tap_val(c3_tap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-lane taps plus the expected event timeline of one
  // command, as cycle offsets after the handshake edge.
  int m_tap [NL];
  int e_moves[$];
  int e_done;
  bit e_err;
  bit e_load;

  task automatic model_cmd(input int op, input int lane, input int steps, input logic [NL-1:0] f);
    int t, k;
    e_moves.delete();
    e_load = 0;
    e_err  = 0;
    e_done = 1;
    if (lane >= NL) begin
      e_err = 1;
      return;
    end
    if (op == 1) begin
      e_load      = 1;
      e_done      = 2 + S;
      m_tap[lane] = INIT;
    end else if (op >= 2 && steps > 0) begin
      t = m_tap[lane];
      k = 0;
      while (k < steps) begin
        if ((op == 2 && t == MAXT) || (op == 3 && t == 0) || f[lane]) begin
          e_err = 1;
          break;
        end
        k++;
        e_moves.push_back(1 + (k - 1) * (1 + S));
        t += (op == 2) ? 1 : -1;
      end
      e_done      = e_err ? 2 + k * (1 + S) : 1 + k * (1 + S);
      m_tap[lane] = t;
    end
  endtask

  function automatic logic [NL*TW-1:0] model_taps();
    logic [NL*TW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(m_tap[i]);
    return v;
  endfunction

  task automatic run_cmd(input int op, input int lane, input int steps, input logic [NL-1:0] f,
                         output int got_done, output bit got_err);
    logic [NL-1:0]     onehot;
    logic [3+2*NL-1:0] act, exp;
    bit                is_mv;
    model_cmd(op, lane, steps, f);
    onehot = NL'(1) << lane;
    @(negedge clk);
    oor = f;
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_lane  = lane[LW-1:0];
    cmd_steps = steps[SW-1:0];
    got_done  = -1;
    got_err   = 0;
    @(posedge clk);
    for (int c = 0; c <= e_done + 2; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (c == 0 && e_moves.size() > 0)
        check($sformatf("dir_early op%0d lane%0d", op, lane), dir[lane], (op == 2));
      if (c >= 1) begin
        is_mv = 0;
        foreach (e_moves[i]) if (e_moves[i] == c) is_mv = 1;
        exp = {c >= e_done, c == e_done, (c == e_done) && e_err,
               is_mv ? onehot : NL'(0), (e_load && c == 1) ? onehot : NL'(0)};
        act = {cmd_ready, done, done_err, mv, ld};
        check($sformatf("cyc%0d op%0d lane%0d steps%0d {rdy,done,err,mv,ld}", c, op, lane, steps),
              act, exp);
        if (is_mv) check($sformatf("dir cyc%0d lane%0d", c, lane), dir[lane], (op == 2));
        if (done && got_done < 0) begin
          got_done = c;
          got_err  = done_err;
        end
        if (c == e_done) check($sformatf("taps after op%0d lane%0d", op, lane), tap_val, model_taps());
      end
      if (c < e_done) begin
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_lane  = LW'($urandom);
        cmd_steps = SW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  typedef struct {
    int               op;
    int               lane;
    int               steps;
    logic [NL-1:0]    oor;
    int               exp_done;
    bit               exp_err;
    logic [NL*TW-1:0] exp_taps;
  } vec_t;

  vec_t vecs [8];
  int   gd;
  bit   ge;
  int   n_done;
  int   c3_done_at;

  initial begin
    vecs[0] = '{2, 1, 3, 2'b00, 16, 0, 16'h0401};
    vecs[1] = '{3, 0, 5, 2'b00,  7, 1, 16'h0400};
    vecs[2] = '{1, 1, 0, 2'b00,  6, 0, 16'h0100};
    vecs[3] = '{2, 0, 2, 2'b01,  2, 1, 16'h0100};
    vecs[4] = '{0, 1, 7, 2'b00,  1, 0, 16'h0100};
    vecs[5] = '{3, 1, 0, 2'b00,  1, 0, 16'h0100};
    vecs[6] = '{2, 0, 2, 2'b00, 11, 0, 16'h0102};
    vecs[7] = '{3, 1, 1, 2'b00,  6, 0, 16'h0002};

    cmd_valid = 0; cmd_op = 0; cmd_lane = 0; cmd_steps = 0; oor = 0;
    c3_valid = 0; c3_op = 0; c3_lane = 0; c3_steps = 0; c3_oor = 0;
    for (int i = 0; i < NL; i++) m_tap[i] = INIT;

    repeat (2) @(posedge clk);
    #1;
    check("in_reset {rdy,done,err,mv,dir,ld}", {cmd_ready, done, done_err, mv, dir, ld}, 9'h100);
    check("in_reset taps", tap_val, 16'h0101);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("post_reset {rdy,done,err,mv,dir,ld}", {cmd_ready, done, done_err, mv, dir, ld}, 9'h100);
    check("post_reset taps", tap_val, 16'h0101);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].op, vecs[i].lane, vecs[i].steps, vecs[i].oor, gd, ge);
      check($sformatf("vec%0d done_offset", i), gd, vecs[i].exp_done);
      check($sformatf("vec%0d done_err", i), ge, vecs[i].exp_err);
      check($sformatf("vec%0d tap_val", i), tap_val, vecs[i].exp_taps);
    end

    // Walk lane 0 up to MAX_TAP; the 17th burst saturates and reports an error.
    run_cmd(1, 0, 0, 2'b00, gd, ge);
    for (int i = 0; i < 17; i++) run_cmd(2, 0, 15, 2'b00, gd, ge);
    check("saturating_burst err", ge, 1);
    check("lane0 at max", tap_val[7:0], 8'd255);
    run_cmd(2, 0, 1, 2'b00, gd, ge);
    check("inc_at_max done_offset", gd, 2);
    check("inc_at_max err", ge, 1);
    run_cmd(3, 0, 2, 2'b00, gd, ge);
    check("dec_from_max lane0", tap_val[7:0], 8'd253);

    for (int i = 0; i < 60; i++) begin
      run_cmd($urandom_range(0, 3), $urandom_range(0, NL - 1), $urandom_range(0, 6),
              ($urandom_range(0, 5) == 0) ? NL'($urandom) : NL'(0), gd, ge);
    end

    // Three-lane build: lane 3 is out of range; lane 2 is legal.
    @(negedge clk);
    c3_valid = 1; c3_op = 2'd2; c3_lane = 2'd3; c3_steps = 4'd2;
    @(posedge clk);
    @(negedge clk);
    c3_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("c3 bad_lane {rdy,done,err,mv,ld}", {c3_ready, c3_done, c3_err, c3_mv, c3_ld}, 9'h1C0);
    check("c3 bad_lane taps", c3_tap, 24'h010101);
    @(negedge clk);
    check("c3 bad_lane single done", c3_done, 0);
    c3_valid = 1; c3_op = 2'd2; c3_lane = 2'd2; c3_steps = 4'd1;
    @(posedge clk);
    @(negedge clk);
    c3_valid = 0;
    c3_done_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("c3 lane2 cyc%0d move", c), c3_mv, (c == 1) ? 3'b100 : 3'b000);
      if (c3_done && c3_done_at < 0) c3_done_at = c;
    end
    check("c3 lane2 done_offset", c3_done_at, 6);
    check("c3 lane2 taps", c3_tap, 24'h020101);

    // Reset during SETTLE of an INC aborts it with no completion.
    @(negedge clk);
    oor = 0; cmd_valid = 1; cmd_op = 2'd2; cmd_lane = 0; cmd_steps = 4'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    @(posedge clk);
    @(negedge clk);
    check("abort move visible", mv, 2'b01);
    #1 arst_n = 1'b0;
    #1;
    check("abort {rdy,done,err,mv,dir,ld}", {cmd_ready, done, done_err, mv, dir, ld}, 9'h100);
    check("abort taps", tap_val, 16'h0101);
    @(negedge clk);
    arst_n = 1'b1;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no done", n_done, 0);
    for (int i = 0; i < NL; i++) m_tap[i] = INIT;
    run_cmd(2, 1, 2, 2'b00, gd, ge);
    check("post_abort done_offset", gd, 11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_dly_tap_ctrl.md
Name: ddr_dly_tap_ctrl

Overview:
Parametrised multi-lane delay-line tap controller for the DDR3 PHY IOD lanes. It accepts LOAD, INC and DEC commands from the training logic over a valid/ready handshake. It converts each command into correctly spaced DELAY_LINE_LOAD, MOVE and DIRECTION strobes on the addressed lane, mirrors the tap setting of every lane, and enforces tap bounds and the IOD out-of-range flag.

Parameters:
NUM_LANES, 2, number of IOD lanes controlled
TAP_W, 8, width of the tap mirror per lane
MAX_TAP, 255, highest legal tap; must be at most 2^TAP_W-1
INIT_TAP, 1, tap value after reset or LOAD (matches IOD TX/RX_DELAY_VAL); INIT_TAP > MAX_TAP is an elaboration error
SETTLE_CYC, 4, idle cycles required after each LOAD or MOVE strobe; must be at least 1
STEP_W, 4, width of the step-count field
LANE_W, max(1,clog2(NUM_LANES)), lane index width (derived)

Ports:
FAB_CLK  in  1  fabric clock, also the IOD TX_CLK
ARST_N  in  1  asynchronous active-low reset
CMD_VALID  in  1  command request
CMD_READY  out  1  high only in IDLE
CMD_OP  in  2  00 NOP, 01 LOAD, 10 INC, 11 DEC
CMD_LANE  in  LANE_W  target lane
CMD_STEPS  in  STEP_W  tap steps for INC/DEC
DONE  out  1  one-cycle completion pulse
DONE_ERR  out  1  valid with DONE; command truncated or rejected
DELAY_LINE_MOVE  out  NUM_LANES  per-lane move strobe
DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction, 1 = increment
DELAY_LINE_LOAD  out  NUM_LANES  per-lane load strobe
DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD out-of-range flag
TAP_VAL  out  NUM_LANES*TAP_W  tap mirror; lane i occupies bits [i*TAP_W +: TAP_W]

Behaviour:
- One clock (FAB_CLK). Reset is asynchronous and active-low (ARST_N).
- On reset:
  - state = IDLE; CMD_READY = 1.
  - DONE, DONE_ERR, MOVE, LOAD and DIRECTION all = 0.
  - Every TAP_VAL lane = INIT_TAP.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.
- Reset asserted mid-command aborts it immediately. No DONE is issued.
- Command handshake: CMD_VALID & CMD_READY in IDLE captures OP, LANE and STEPS. Inputs are ignored at all other times.
- Decode at capture:
  - CMD_LANE >= NUM_LANES -> DONE with DONE_ERR=1. No strobes.
  - NOP, or INC/DEC with STEPS=0 -> DONE with DONE_ERR=0.
  - LOAD -> LOAD state.
  - INC/DEC -> MOVE state.
- LOAD state (one cycle):
  - DELAY_LINE_LOAD[lane] = 1; tap[lane] <= INIT_TAP.
  - Go to SETTLE with remaining = 0.
- MOVE state (one cycle). A step is blocked if any of these holds:
  - INC and tap == MAX_TAP
  - DEC and tap == 0
  - DELAY_LINE_OUT_OF_RANGE[lane] == 1 (sampled this cycle)
- If blocked: set the error flag, go to DONE, emit no strobe.
- If not blocked:
  - MOVE[lane] = 1; DIRECTION[lane] <= (op==INC).
  - tap[lane] increments or decrements by 1; remaining decrements by 1.
  - Go to SETTLE.
- DIRECTION[lane] is set one cycle before its MOVE pulse is visible, and it holds until that lane's next move. Other lanes are untouched.
- SETTLE: counts SETTLE_CYC cycles with no strobes. Then it goes to MOVE if remaining > 0, otherwise to DONE.
- DONE (one cycle):
  - DONE = 1; DONE_ERR = error flag.
  - Go to IDLE; the error flag clears.
  - Steps executed before an error are retained in TAP_VAL.
- Latency, with T = handshake cycle:
  - LOAD: strobe at T+1, DONE at T+2+SETTLE_CYC.
  - INC/DEC with n unblocked steps: k-th MOVE at T+1+(k-1)(1+SETTLE_CYC), DONE at T+1+n(1+SETTLE_CYC).
  - Rejected, NOP or zero-step command: DONE at T+1.
- Back-to-back commands: the next command is accepted on the cycle after DONE, since the block is in IDLE.
- At most one strobe is high in any cycle across all lanes.

Decomposition:
- Package ddr_dly_pkg:
  - CMD_OP encodings (NOP, LOAD, INC, DEC)
  - FSM state enum (IDLE, LOAD, MOVE, SETTLE, DONE)
  - clog2-based LANE_W helper
- No sub-module. The FSM, settle counter and per-lane tap register array stay in one module.

Test Plan:
- Reset release -> CMD_READY=1; all strobes, DONE and DONE_ERR = 0; TAP_VAL = {8'd1, 8'd1}.
- INC, lane 1, steps 3 at T -> MOVE[1] at T+1, T+6 and T+11; DIRECTION[1]=1; lane 1 tap = 4; DONE at T+16 with DONE_ERR=0; lane 0 unchanged.
- DEC, lane 0, steps 5 from tap 1 -> single MOVE[0] at T+1, tap = 0; limit detected at T+6; DONE with DONE_ERR=1 at T+7.
- LOAD, lane 1 with tap 4 -> LOAD[1] at T+1; tap = 1; DONE at T+6, DONE_ERR=0.
- OUT_OF_RANGE[0]=1, then INC lane 0 steps 2 -> no MOVE; DONE and DONE_ERR at T+2; tap unchanged.
- NUM_LANES=3 build, command to lane 3 -> DONE_ERR at T+1 with no strobes. Separately, ARST_N low during SETTLE of an INC -> outputs clear immediately, taps = INIT_TAP, no DONE.
